// File: rtl/semaforo_pkg.sv
// Shared definitions for the single-intersection traffic-light controller:
// state encoding, lamp bundle and the lamp decoder.
package semaforo_pkg;

    localparam int STATE_W = 2;

    typedef logic [STATE_W-1:0] state_t;

    localparam state_t S_GREEN   = 2'b00;
    localparam state_t S_YELLOW  = 2'b01;
    localparam state_t S_RED     = 2'b10;
    localparam state_t S_ILLEGAL = 2'b11;

    typedef struct packed {
        logic grn;
        logic ylw;
        logic red;
    } lamps_t;

    // The unused encoding turns every lamp off.
    function automatic lamps_t decode_lamps(input state_t s);
        lamps_t l;
        l.grn = (s == S_GREEN);
        l.ylw = (s == S_YELLOW);
        l.red = (s == S_RED);
        return l;
    endfunction

endpackage

// File: rtl/semaforo_state_reg.sv
// Two-bit state register of the traffic-light controller.
// It resets asynchronously to the green state.
module semaforo_state_reg
    import semaforo_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [STATE_W-1:0] d,
    output logic [STATE_W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= S_GREEN;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/semaforo.sv
// Moore traffic-light controller: GREEN -> YELLOW -> RED -> GREEN.
// A car leaves green; the external red timer ends red.
module semaforo
    import semaforo_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic CAR,
    input  logic TIMEOUT,
    output logic GRN,
    output logic YLW,
    output logic RED
);

    state_t state;
    state_t state_next;
    lamps_t lamps;

    semaforo_state_reg u_state_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (state_next),
        .q     (state)
    );

    always_comb begin
        state_next = S_GREEN;
        unique case (state)
            S_GREEN: begin
                state_next = CAR ? S_YELLOW : S_GREEN;
            end
            S_YELLOW: begin
                state_next = S_RED;
            end
            S_RED: begin
                state_next = TIMEOUT ? S_GREEN : S_RED;
            end
            S_ILLEGAL: begin
                state_next = S_GREEN;
            end
        endcase
    end

    // Lamps come only from the registered state, never from the inputs.
    always_comb begin
        lamps = decode_lamps(state);
    end

    assign GRN = lamps.grn;
    assign YLW = lamps.ylw;
    assign RED = lamps.red;

endmodule

// File: tb/tb_semaforo.sv
// Scoreboard bench for the traffic-light controller.
// Expected lamps are queued when inputs are driven and checked after the edge.
module tb_semaforo;

    logic clk;
    logic rst_n;
    logic CAR;
    logic TIMEOUT;
    logic GRN;
    logic YLW;
    logic RED;

    typedef enum logic [1:0] {M_G, M_Y, M_R} mstate_t;

    mstate_t    m_state;
    logic [2:0] sb[$];
    int         n_cmp;
    int         n_err;
    int         ylw_run;

    semaforo dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .CAR     (CAR),
        .TIMEOUT (TIMEOUT),
        .GRN     (GRN),
        .YLW     (YLW),
        .RED     (RED)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [2:0] got,
                       input logic [2:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t",
                     tag, got, exp, $time);
        end
    endtask

    function automatic logic [2:0] lamps_of(input mstate_t s);
        case (s)
            M_G:     return 3'b100;
            M_Y:     return 3'b010;
            M_R:     return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    function automatic mstate_t model_next(input mstate_t s,
                                           input logic c,
                                           input logic t);
        if (s == M_G) return c ? M_Y : M_G;
        if (s == M_Y) return M_R;
        return t ? M_G : M_R;
    endfunction

    task automatic expect_now();
        sb.push_back(lamps_of(m_state));
    endtask

    task automatic pop_cmp(input string tag);
        logic [2:0] exp;
        if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            exp = sb.pop_front();
            chk(tag, {GRN, YLW, RED}, exp);
        end
    endtask

    task automatic cycle(input string tag, input logic c, input logic t);
        CAR     = c;
        TIMEOUT = t;
        m_state = model_next(m_state, c, t);
        expect_now();
        @(posedge clk);
        #1;
        pop_cmp(tag);
        chk({tag, "_onehot"}, 3'($countones({GRN, YLW, RED})), 3'd1);
        if (YLW) ylw_run++;
        else     ylw_run = 0;
        chk({tag, "_ylw1"}, {2'b00, ylw_run > 1}, 3'b000);
    endtask

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        ylw_run = 0;
        m_state = M_G;
        rst_n   = 1'b0;
        CAR     = 1'b1;
        TIMEOUT = 1'b1;

        // Reset with both inputs active.
        #1;
        expect_now();
        pop_cmp("rst_during");
        @(posedge clk);
        #1;
        expect_now();
        pop_cmp("rst_edge");
        @(negedge clk);
        CAR   = 1'b0;
        rst_n = 1'b1;
        cycle("rst_release", 1'b0, 1'b0);

        // Green ignores TIMEOUT.
        for (int i = 0; i < 5; i++) cycle("green_hold", 1'b0, 1'b1);

        // One-cycle car pulse, then red held with CAR toggling.
        cycle("car_y", 1'b1, 1'b0);
        cycle("car_r", 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cycle("red_hold", 1'(i), 1'b0);

        // Timeout returns to green, which then holds.
        cycle("timeout_g", 1'b0, 1'b1);
        cycle("g_after", 1'b0, 1'b0);
        cycle("g_after", 1'b0, 1'b0);

        // CAR held high: the loop keeps repeating.
        for (int i = 0; i < 16; i++)
            cycle("car_held", 1'b1, 1'((i % 3) == 2));

        // Random traffic.
        for (int i = 0; i < 40; i++)
            cycle("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

        // Drive into red, then reset between edges.
        while (m_state != M_G) cycle("to_green", 1'b0, 1'b1);
        cycle("to_y", 1'b1, 1'b0);
        cycle("to_r", 1'b0, 1'b0);
        #3;
        rst_n   = 1'b0;
        m_state = M_G;
        #1;
        expect_now();
        pop_cmp("async_rst");
        @(posedge clk);
        #1;
        expect_now();
        pop_cmp("async_hold");
        @(negedge clk);
        rst_n   = 1'b1;
        ylw_run = 0;
        cycle("post_rst", 1'b1, 1'b0);
        cycle("post_rst_r", 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
